// File: rtl/d5m_stream_pkg.sv
// ============================================================================
// Module   : d5m_stream_pkg
// Purpose  : Shared state and pattern-mode encodings for the D5M stream generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package d5m_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FRONT  = 3'd1,
        S_LINE   = 3'd2,
        S_HBLANK = 3'd3,
        S_VBLANK = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_XRAMP   = 2'd0,
        MODE_YRAMP   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_CONST   = 2'd3
    } mode_e;

    localparam int PIX_W  = 12;
    localparam int CNT_W  = 16;
    localparam int FCNT_W = 32;

endpackage : d5m_stream_pkg

`default_nettype wire

// File: rtl/d5m_pixel_pattern.sv
// ============================================================================
// Module   : d5m_pixel_pattern
// Purpose  : Combinational test-pattern pixel generator (ramps, checkerboard, constant).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module d5m_pixel_pattern
    import d5m_stream_pkg::*;
#(
    parameter logic [PIX_W-1:0] PAT_CONST = 12'h800
) (
    input  mode_e            mode_i,
    input  logic [PIX_W-1:0] x_i,
    input  logic [PIX_W-1:0] y_i,
    output logic [PIX_W-1:0] pixel_o
);

    always_comb begin
        pixel_o = '0;
        case (mode_i)
            MODE_XRAMP:   pixel_o = x_i;
            MODE_YRAMP:   pixel_o = y_i;
            // 8x8 tiles: bit 3 of each coordinate toggles every eight pixels/lines
            MODE_CHECKER: pixel_o = (x_i[3] ^ y_i[3]) ? 12'hFFF : 12'h000;
            MODE_CONST:   pixel_o = PAT_CONST;
            default:      pixel_o = '0;
        endcase
    end

endmodule : d5m_pixel_pattern

`default_nettype wire

// File: rtl/d5m_stream_gen.sv
// ============================================================================
// Module   : d5m_stream_gen
// Purpose  : D5M-style FVAL/LVAL/DATA test stream generator with frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module d5m_stream_gen
    import d5m_stream_pkg::*;
#(
    parameter int                H_ACTIVE  = 1280,
    parameter int                H_BLANK   = 64,
    parameter int                V_ACTIVE  = 960,
    parameter int                V_FRONT   = 16,
    parameter int                V_BLANK   = 128,
    parameter logic [PIX_W-1:0]  PAT_CONST = 12'h800
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSTART,
    input  logic              iSTOP,
    input  logic [1:0]        iMODE,
    output logic [PIX_W-1:0]  oDATA,
    output logic              oLVAL,
    output logic              oFVAL,
    output logic [FCNT_W-1:0] oFrame_Cont,
    output logic              oBUSY
);

    localparam logic [CNT_W-1:0] c_front_last = CNT_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0] c_line_last  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_hblk_last  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] c_vblk_last  = CNT_W'(V_BLANK - 1);
    localparam logic [PIX_W-1:0] c_row_last   = PIX_W'(V_ACTIVE - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PIX_W-1:0]    x_q, x_d;
    logic [PIX_W-1:0]    y_q, y_d;
    mode_e               mode_q, mode_d;
    logic                stop_q, stop_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                start_frame;
    logic [PIX_W-1:0]    pixel;

    logic [PIX_W-1:0]    data_q;
    logic                lval_q, fval_q, busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        stop_d      = stop_q | iSTOP;
        fcnt_d      = fcnt_q;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                stop_d = 1'b0;
                if (iSTART && !iSTOP) begin
                    start_frame = 1'b1;
                end
            end
            S_FRONT: begin
                if (cnt_q == c_front_last) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                    x_d     = '0;
                end
            end
            S_LINE: begin
                x_d = x_q + 12'd1;
                if (cnt_q == c_line_last) begin
                    state_d = S_HBLANK;
                    cnt_d   = '0;
                end
            end
            S_HBLANK: begin
                if (cnt_q == c_hblk_last) begin
                    cnt_d = '0;
                    if (y_q == c_row_last) begin
                        state_d = S_VBLANK;
                        fcnt_d  = fcnt_q + 32'd1;
                    end else begin
                        state_d = S_LINE;
                        x_d     = '0;
                        y_d     = y_q + 12'd1;
                    end
                end
            end
            S_VBLANK: begin
                if (cnt_q == c_vblk_last) begin
                    if (stop_q || iSTOP) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        start_frame = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                stop_d  = 1'b0;
            end
        endcase

        // Shared FRONT entry from IDLE or back-to-back from VBLANK
        if (start_frame) begin
            state_d = S_FRONT;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
            mode_d  = mode_e'(iMODE);
        end
    end

    d5m_pixel_pattern #(
        .PAT_CONST (PAT_CONST)
    ) u_pattern (
        .mode_i  (mode_d),
        .x_i     (x_d),
        .y_i     (y_d),
        .pixel_o (pixel)
    );

    // Outputs are decoded from next-state so they land in the same cycle as the state
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= MODE_XRAMP;
            stop_q  <= 1'b0;
            fcnt_q  <= '0;
            data_q  <= '0;
            lval_q  <= 1'b0;
            fval_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            stop_q  <= stop_d;
            fcnt_q  <= fcnt_d;
            data_q  <= (state_d == S_LINE) ? pixel : '0;
            lval_q  <= (state_d == S_LINE);
            fval_q  <= (state_d == S_FRONT) || (state_d == S_LINE) || (state_d == S_HBLANK);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign oDATA       = data_q;
    assign oLVAL       = lval_q;
    assign oFVAL       = fval_q;
    assign oFrame_Cont = fcnt_q;
    assign oBUSY       = busy_q;

endmodule : d5m_stream_gen

`default_nettype wire

// File: tb/tb_d5m_stream_gen.sv
// ============================================================================
// Module   : tb_d5m_stream_gen
// Purpose  : Self-checking bench: two DUT widths against a frame-phase reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d5m_stream_gen;

    localparam int HB = 4;
    localparam int VA = 4;
    localparam int VF = 2;
    localparam int VB = 6;

    logic iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic        rst, start, stop;
    logic [1:0]  mode;

    logic [11:0] data0, data1;
    logic        lval0, lval1, fval0, fval1, busy0, busy1;
    logic [31:0] fc0, fc1;

    d5m_stream_gen #(
        .H_ACTIVE(8), .H_BLANK(HB), .V_ACTIVE(VA), .V_FRONT(VF), .V_BLANK(VB), .PAT_CONST(12'h800)
    ) u_dut8 (
        .iCLK(iCLK), .iRST(rst), .iSTART(start), .iSTOP(stop), .iMODE(mode),
        .oDATA(data0), .oLVAL(lval0), .oFVAL(fval0), .oFrame_Cont(fc0), .oBUSY(busy0)
    );

    d5m_stream_gen #(
        .H_ACTIVE(16), .H_BLANK(HB), .V_ACTIVE(VA), .V_FRONT(VF), .V_BLANK(VB), .PAT_CONST(12'h800)
    ) u_dut16 (
        .iCLK(iCLK), .iRST(rst), .iSTART(start), .iSTOP(stop), .iMODE(mode),
        .oDATA(data1), .oLVAL(lval1), .oFVAL(fval1), .oFrame_Cont(fc1), .oBUSY(busy1)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: frame described only by its phase since the first FVAL cycle
    int          m_ha   [2];
    bit          m_act  [2];
    int          m_ph   [2];
    int          m_mode [2];
    bit          m_stop [2];
    logic [31:0] m_fc   [2];

    int t_fval, t_lval, n_fval, n_burst;
    logic prev_lval0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_update(input int k);
        int fvl, per;
        fvl = VF + VA * (m_ha[k] + HB);
        per = fvl + VB;
        if (rst) begin
            m_act[k]  = 1'b0;
            m_stop[k] = 1'b0;
            m_fc[k]   = '0;
            m_ph[k]   = 0;
        end else if (!m_act[k]) begin
            if (start && !stop) begin
                m_act[k]  = 1'b1;
                m_ph[k]   = 0;
                m_mode[k] = int'(mode);
            end
        end else begin
            m_stop[k] = m_stop[k] | stop;
            if (m_ph[k] == per - 1) begin
                if (m_stop[k]) begin
                    m_act[k]  = 1'b0;
                    m_stop[k] = 1'b0;
                end else begin
                    m_ph[k]   = 0;
                    m_mode[k] = int'(mode);
                end
            end else begin
                m_ph[k]++;
                if (m_ph[k] == fvl) m_fc[k]++;
            end
        end
    endtask

    task automatic compare_dut(input int k);
        int fvl, line, p2, x, y;
        bit e_f, e_l;
        logic [11:0] e_d;
        logic [11:0] g_d;
        logic        g_l, g_f, g_b;
        logic [31:0] g_fc;
        fvl  = VF + VA * (m_ha[k] + HB);
        line = m_ha[k] + HB;
        p2   = m_ph[k] - VF;
        e_f  = m_act[k] && (m_ph[k] < fvl);
        e_l  = e_f && (p2 >= 0) && ((p2 % line) < m_ha[k]);
        e_d  = 12'h000;
        if (e_l) begin
            x = p2 % line;
            y = p2 / line;
            case (m_mode[k])
                0:       e_d = 12'(x);
                1:       e_d = 12'(y);
                2:       e_d = ((((x / 8) % 2) != ((y / 8) % 2))) ? 12'hFFF : 12'h000;
                default: e_d = 12'h800;
            endcase
        end
        g_d  = (k == 0) ? data0 : data1;
        g_l  = (k == 0) ? lval0 : lval1;
        g_f  = (k == 0) ? fval0 : fval1;
        g_b  = (k == 0) ? busy0 : busy1;
        g_fc = (k == 0) ? fc0   : fc1;
        check_value($sformatf("fval%0d", k), 32'(g_f), 32'(e_f));
        check_value($sformatf("lval%0d", k), 32'(g_l), 32'(e_l));
        check_value($sformatf("data%0d", k), 32'(g_d), 32'(e_d));
        check_value($sformatf("busy%0d", k), 32'(g_b), 32'(m_act[k]));
        check_value($sformatf("fcnt%0d", k), g_fc, m_fc[k]);
    endtask

    task automatic step();
        @(posedge iCLK);
        model_update(0);
        model_update(1);
        cyc++;
        #1;
        compare_dut(0);
        compare_dut(1);
        if (fval0 && t_fval < 0) t_fval = cyc;
        if (lval0 && t_lval < 0) t_lval = cyc;
        if (cyc >= 11 && cyc <= 66) begin
            if (fval0) n_fval++;
            if (lval0 && !prev_lval0) n_burst++;
        end
        prev_lval0 = lval0;
    endtask

    task automatic run_until(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        m_ha[0] = 8;
        m_ha[1] = 16;
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_ph[k] = 0; m_mode[k] = 0; m_stop[k] = 0; m_fc[k] = '0;
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
        step();
        step();
        check_value("reset_fval", 32'(fval0), 32'd0);
        check_value("reset_fcnt", fc0, 32'd0);
        rst = 1'b0;
        cyc = 0;
        t_fval = -1; t_lval = -1; n_fval = 0; n_burst = 0; prev_lval0 = 1'b0;

        // Single start pulse, continuous streaming, then a stop mid-line 2 of frame 2
        run_until(10);
        start = 1'b1;
        step();
        start = 1'b0;
        run_until(60);
        check_value("fcnt_c60", fc0, 32'd0);
        step();
        check_value("fcnt_c61", fc0, 32'd1);
        run_until(66);
        check_value("first_fval", 32'(t_fval), 32'd11);
        check_value("first_lval", 32'(t_lval), 32'd13);
        check_value("fval_len", 32'(n_fval), 32'd50);
        check_value("lval_bursts", 32'(n_burst), 32'd4);
        check_value("fval_c66", 32'(fval0), 32'd0);
        step();
        check_value("refire_c67", 32'(fval0), 32'd1);
        run_until(95);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run_until(122);
        check_value("busy_c122", 32'(busy0), 32'd1);
        step();
        check_value("idle_c123", 32'(busy0), 32'd0);
        check_value("fcnt_c123", fc0, 32'd2);

        // Reset mid-line clears everything; nothing restarts without a new start
        run_until(140);
        mode  = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        run_until(145);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_value("rst_lval", 32'(lval0), 32'd0);
        check_value("rst_fval", 32'(fval0), 32'd0);
        check_value("rst_data", 32'(data0), 32'd0);
        check_value("rst_fcnt", fc0, 32'd0);
        run_until(170);
        check_value("rst_stay_idle", 32'(busy0), 32'd0);

        // Ramp frame, switch to checkerboard mid-frame; it takes effect next frame
        mode  = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_until(200);
        mode = 2'd2;
        run_until(440);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run_until(600);

        // Randomized control traffic
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_d5m_stream_gen

`default_nettype wire
